// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: TX state encoding, framing constants
// and a byte-wide reflected CRC-32 step used by the TX and RX FCS logic.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  typedef struct packed {
    logic       en;
    logic [1:0] d;
  } rmii_tx_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] crc,
    input logic [7:0]  data
  );
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (CRC_POLY & {32{c[0] ^ data[i]}});
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_gen.sv
// Registered reflected CRC-32, one byte per enabled cycle, LSB first.
// clr has priority over en and restores the initial value.
module crc32_gen
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/rmii_transmitter.sv
// RMII frame transmitter: preamble/SFD, FIFO bytes, zero pad, FCS, IFG.
// Dibits are computed a cycle ahead and registered onto tx_en/tx_d.
module rmii_transmitter
  import eth_pkg::*;
#(
  parameter int MIN_FRAME  = 60,
  parameter int MAX_FRAME  = 1514,
  parameter int IFG_CYCLES = 48
) (
  input  logic        clk_50_mhz,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] frame_len,
  input  logic [7:0]  data_i,
  input  logic        empty,
  output logic        read_en,
  output logic        tx_en,
  output logic [1:0]  tx_d,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  tx_state_t   state;
  tx_state_t   state_nx;
  logic [1:0]  ph;
  logic [15:0] byte_cnt;
  logic [15:0] len;
  logic [15:0] ifg_cnt;
  logic [7:0]  shreg;
  logic [7:0]  cur_byte;
  logic        abort_q;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic        accept;
  logic        slot_start;
  logic        slot_end;
  logic        in_tx;
  logic        under;
  logic        last_data;
  logic        pad_done;
  logic        ifg_last;
  logic        crc_clr;
  logic        crc_en;
  rmii_tx_t    tx_nx;

  assign accept = (state == ST_IDLE) && start
               && (frame_len != 16'd0)
               && (frame_len <= 16'(MAX_FRAME));

  assign slot_start = (ph == 2'd0);
  assign slot_end   = (ph == 2'd3);
  assign in_tx      = (state == ST_PREAMBLE) || (state == ST_DATA)
                   || (state == ST_PAD) || (state == ST_FCS);
  assign under      = (state == ST_DATA) && slot_start && empty;
  assign last_data  = (byte_cnt == len - 16'd1);
  assign pad_done   = (byte_cnt == 16'(MIN_FRAME - 1));
  assign ifg_last   = (ifg_cnt == 16'(IFG_CYCLES - 1));
  assign fcs        = ~crc;

  always_ff @(posedge clk_50_mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (slot_end && byte_cnt == 16'd7) state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (under) begin
          state_nx = ST_IFG;
        end else if (slot_end && last_data) begin
          state_nx = (len < 16'(MIN_FRAME)) ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        if (slot_end && pad_done) state_nx = ST_FCS;
      end
      ST_FCS: begin
        if (slot_end && byte_cnt == 16'd3) state_nx = ST_IFG;
      end
      ST_IFG: begin
        if (ifg_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_byte = shreg;
    if (slot_start) begin
      unique case (state)
        ST_PREAMBLE: cur_byte = (byte_cnt == 16'd7) ? SFD_BYTE : PREAMBLE_BYTE;
        ST_DATA:     cur_byte = data_i;
        ST_PAD:      cur_byte = 8'h00;
        ST_FCS:      cur_byte = fcs[{byte_cnt[1:0], 3'b000} +: 8];
        default:     cur_byte = shreg;
      endcase
    end
  end

  always_comb begin
    read_en  = (state == ST_DATA) && slot_start && !empty;
    underrun = under;
    done     = (state == ST_IFG) && ifg_last && !abort_q;
    busy     = (state != ST_IDLE);
    crc_clr  = accept;
    crc_en   = slot_start && !under
            && ((state == ST_DATA) || (state == ST_PAD));
    tx_nx.en = in_tx && !under;
    tx_nx.d  = tx_nx.en ? cur_byte[{ph, 1'b0} +: 2] : 2'b00;
  end

  // Pad keeps counting from the data byte count; other states restart at 0.
  always_ff @(posedge clk_50_mhz or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= 2'd0;
      byte_cnt <= 16'd0;
      len      <= 16'd0;
      ifg_cnt  <= 16'd0;
      shreg    <= 8'h00;
      abort_q  <= 1'b0;
    end else begin
      ph      <= (in_tx && !under) ? ph + 2'd1 : 2'd0;
      ifg_cnt <= (state == ST_IFG) ? ifg_cnt + 16'd1 : 16'd0;
      if (state_nx != state) begin
        byte_cnt <= (state_nx == ST_PAD) ? byte_cnt + 16'd1 : 16'd0;
      end else if (in_tx && slot_end) begin
        byte_cnt <= byte_cnt + 16'd1;
      end
      if (accept) len <= frame_len;
      if (in_tx && slot_start) shreg <= cur_byte;
      if (under) begin
        abort_q <= 1'b1;
      end else if (accept) begin
        abort_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50_mhz or negedge rst_n) begin
    if (!rst_n) begin
      tx_en <= 1'b0;
      tx_d  <= 2'b00;
    end else begin
      tx_en <= tx_nx.en;
      tx_d  <= tx_nx.d;
    end
  end

  crc32_gen u_crc (
    .clk   (clk_50_mhz),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .data  (cur_byte),
    .crc   (crc)
  );

endmodule

// File: tb/tb_rmii_transmitter.sv
// Scoreboard bench for rmii_transmitter: expected wire bytes are queued
// at start, received dibits are reassembled and compared per byte.
`timescale 1ns/1ps
module tb_rmii_transmitter;

  logic        clk_50_mhz = 1'b0;
  logic        rst_n      = 1'b0;
  logic        start      = 1'b0;
  logic [15:0] frame_len  = 16'd0;
  logic [7:0]  data_i     = 8'h00;
  logic        empty      = 1'b1;
  logic        read_en;
  logic        tx_en;
  logic [1:0]  tx_d;
  logic        busy;
  logic        done;
  logic        underrun;

  logic        c_clr  = 1'b0;
  logic        c_en   = 1'b0;
  logic [7:0]  c_data = 8'h00;
  logic [31:0] c_crc;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [1:0] rx_q[$];
  int  cyc = 0, n_read = 0, n_busy = 0, n_done = 0, n_under = 0, txd_bad = 0;
  int  done_cyc = -1, under_cyc = -1, fall_cyc = -1;
  bit  prev_busy = 0, pop_pend = 0;

  always #10 clk_50_mhz = ~clk_50_mhz;

  rmii_transmitter dut (
    .clk_50_mhz (clk_50_mhz),
    .rst_n      (rst_n),
    .start      (start),
    .frame_len  (frame_len),
    .data_i     (data_i),
    .empty      (empty),
    .read_en    (read_en),
    .tx_en      (tx_en),
    .tx_d       (tx_d),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  crc32_gen u_crc (
    .clk   (clk_50_mhz),
    .rst_n (rst_n),
    .clr   (c_clr),
    .en    (c_en),
    .data  (c_data),
    .crc   (c_crc)
  );

  function automatic void fifo_refresh();
    empty  = (fifo_q.size() == 0);
    data_i = empty ? 8'h00 : fifo_q[0];
  endfunction

  always @(negedge clk_50_mhz) begin
    cyc++;
    if (tx_en) rx_q.push_back(tx_d);
    else if (tx_d != 2'b00) txd_bad++;
    if (read_en) n_read++;
    if (busy) n_busy++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (underrun) begin n_under++; under_cyc = cyc; end
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
    pop_pend  = read_en;
  end

  always @(posedge clk_50_mhz) begin
    #1;
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pend = 0;
    fifo_refresh();
  end

  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  function automatic void clear_stats();
    rx_q.delete();
    n_read = 0; n_busy = 0; n_done = 0; n_under = 0; txd_bad = 0;
    done_cyc = -1; under_cyc = -1; fall_cyc = -1;
  endfunction

  // Loads FIFO with the frame bytes and queues the expected wire bytes.
  function automatic void load_frame(input int len, input int avail, input bit counting);
    logic [7:0] b;
    logic [31:0] c;
    int total;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < len; i++) begin
      b = counting ? 8'(i + 1) : 8'($urandom_range(0, 255));
      if (i < avail) begin
        fifo_q.push_back(b);
        exp_q.push_back(b);
      end
      c = model_crc(c, b);
    end
    if (avail >= len) begin
      total = (len < 60) ? 60 : len;
      for (int i = len; i < total; i++) begin
        exp_q.push_back(8'h00);
        c = model_crc(c, 8'h00);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    end
    fifo_refresh();
  endfunction

  task automatic send_wait(input logic [15:0] len, input int limit, output bit timed_out);
    @(negedge clk_50_mhz);
    start = 1'b1;
    frame_len = len;
    @(negedge clk_50_mhz);
    start = 1'b0;
    timed_out = 1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_50_mhz);
      if (!busy) begin timed_out = 0; break; end
    end
    repeat (3) @(posedge clk_50_mhz);
    #2;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b exp 0", tx_en); end
    checks++; if (tx_d !== 2'b00) begin errors++; $display("FAIL reset_tx_d got %b exp 00", tx_d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en got %b exp 0", read_en); end
    checks++; if (done !== 1'b0 || underrun !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got done=%b underrun=%b exp 0", done, underrun);
    end
    checks++; if (c_crc !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_crc got %h exp ffffffff", c_crc); end
  endtask

  task automatic test_crc();
    logic [7:0] s[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    @(negedge clk_50_mhz);
    c_clr = 1'b1;
    @(negedge clk_50_mhz);
    c_clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      c_en = 1'b1; c_data = s[i];
      @(negedge clk_50_mhz);
    end
    c_en = 1'b0;
    checks++; if (~c_crc !== 32'hCBF43926) begin
      errors++; $display("FAIL crc_check got %h exp cbf43926", ~c_crc);
    end
  endtask

  task automatic test_short_pad();
    bit to; logic [7:0] eb, rb; logic [1:0] d0, d1, d2, d3;
    clear_stats(); exp_q.delete();
    load_frame(14, 14, 0);
    send_wait(16'd14, 2000, to);
    checks++; if (to) begin errors++; $display("FAIL short_timeout busy still high"); end
    checks++; if (rx_q.size() != 288) begin errors++; $display("FAIL short_txen_cycles got %0d exp 288", rx_q.size()); end
    checks++; if (n_read != 14) begin errors++; $display("FAIL short_reads got %0d exp 14", n_read); end
    checks++; if (n_busy != 336) begin errors++; $display("FAIL short_busy got %0d exp 336", n_busy); end
    checks++; if (n_done != 1 || fall_cyc != done_cyc + 1) begin
      errors++; $display("FAIL short_done got n=%0d at %0d exp 1 at %0d", n_done, done_cyc, fall_cyc - 1);
    end
    checks++; if (n_under != 0 || txd_bad != 0) begin
      errors++; $display("FAIL short_misc got under=%0d txd_bad=%0d exp 0", n_under, txd_bad);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      eb = exp_q.pop_front();
      rb = 8'hxx;
      if (rx_q.size() >= 4) begin
        d0 = rx_q.pop_front(); d1 = rx_q.pop_front();
        d2 = rx_q.pop_front(); d3 = rx_q.pop_front();
        rb = {d3, d2, d1, d0};
      end
      checks++; if (rb !== eb) begin errors++; $display("FAIL short_byte%0d got %h exp %h", i, rb, eb); end
    end
  endtask

  task automatic test_long_counting();
    bit to; logic [7:0] eb, rb; logic [1:0] d0, d1, d2, d3;
    clear_stats(); exp_q.delete();
    load_frame(100, 100, 1);
    send_wait(16'd100, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL long_timeout busy still high"); end
    checks++; if (rx_q.size() != 448) begin errors++; $display("FAIL long_txen_cycles got %0d exp 448", rx_q.size()); end
    checks++; if (n_read != 100) begin errors++; $display("FAIL long_reads got %0d exp 100", n_read); end
    checks++; if (n_busy != 496 || n_done != 1) begin
      errors++; $display("FAIL long_busy got %0d done=%0d exp 496 done=1", n_busy, n_done);
    end
    checks++; if (rx_q.size() < 36 || {rx_q[32], rx_q[33], rx_q[34], rx_q[35]} !== 8'b01_00_00_00) begin
      errors++; $display("FAIL long_dibit_order first data byte dibits wrong exp 01,00,00,00");
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      eb = exp_q.pop_front();
      rb = 8'hxx;
      if (rx_q.size() >= 4) begin
        d0 = rx_q.pop_front(); d1 = rx_q.pop_front();
        d2 = rx_q.pop_front(); d3 = rx_q.pop_front();
        rb = {d3, d2, d1, d0};
      end
      checks++; if (rb !== eb) begin errors++; $display("FAIL long_byte%0d got %h exp %h", i, rb, eb); end
    end
  endtask

  task automatic test_underrun();
    bit to; logic [7:0] eb, rb; logic [1:0] d0, d1, d2, d3;
    clear_stats(); exp_q.delete();
    load_frame(64, 20, 0);
    send_wait(16'd64, 2000, to);
    checks++; if (to) begin errors++; $display("FAIL under_timeout busy still high"); end
    checks++; if (n_under != 1) begin errors++; $display("FAIL under_pulses got %0d exp 1", n_under); end
    checks++; if (n_done != 0) begin errors++; $display("FAIL under_done got %0d exp 0", n_done); end
    checks++; if (n_read != 20) begin errors++; $display("FAIL under_reads got %0d exp 20", n_read); end
    checks++; if (rx_q.size() != 112) begin errors++; $display("FAIL under_txen_cycles got %0d exp 112", rx_q.size()); end
    checks++; if (fall_cyc - under_cyc != 49) begin
      errors++; $display("FAIL under_ifg got %0d exp 49", fall_cyc - under_cyc);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      eb = exp_q.pop_front();
      rb = 8'hxx;
      if (rx_q.size() >= 4) begin
        d0 = rx_q.pop_front(); d1 = rx_q.pop_front();
        d2 = rx_q.pop_front(); d3 = rx_q.pop_front();
        rb = {d3, d2, d1, d0};
      end
      checks++; if (rb !== eb) begin errors++; $display("FAIL under_byte%0d got %h exp %h", i, rb, eb); end
    end
  endtask

  task automatic test_ignored_starts();
    bit to;
    clear_stats(); exp_q.delete(); fifo_q.delete(); fifo_refresh();
    fifo_q.push_back(8'hAA); fifo_refresh();
    send_wait(16'd0, 10, to);
    send_wait(16'd1515, 10, to);
    checks++; if (n_busy != 0 || rx_q.size() != 0 || n_read != 0) begin
      errors++; $display("FAIL bad_len got busy=%0d tx=%0d reads=%0d exp 0", n_busy, rx_q.size(), n_read);
    end
    fifo_q.delete(); fifo_refresh();
    clear_stats();
    load_frame(14, 14, 0);
    @(negedge clk_50_mhz); start = 1'b1; frame_len = 16'd14;
    @(negedge clk_50_mhz); start = 1'b0;
    repeat (60) @(negedge clk_50_mhz);
    start = 1'b1; frame_len = 16'd20;
    @(negedge clk_50_mhz); start = 1'b0;
    to = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_50_mhz);
      if (!busy) begin to = 0; break; end
    end
    repeat (20) @(negedge clk_50_mhz);
    #2;
    checks++; if (to) begin errors++; $display("FAIL busy_start_timeout busy still high"); end
    checks++; if (n_busy != 336 || n_read != 14 || rx_q.size() != 288 || n_under != 0) begin
      errors++; $display("FAIL busy_start got busy=%0d reads=%0d tx=%0d under=%0d exp 336 14 288 0",
                         n_busy, n_read, rx_q.size(), n_under);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_fcs();
    bit to, hit; logic [7:0] eb, rb; logic [1:0] d0, d1, d2, d3;
    clear_stats(); exp_q.delete();
    load_frame(30, 30, 0);
    @(negedge clk_50_mhz); start = 1'b1; frame_len = 16'd30;
    @(negedge clk_50_mhz); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_50_mhz);
      if (rx_q.size() >= 276) begin hit = 1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_reach_fcs got %0d dibits exp 276", rx_q.size()); end
    #7;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_en !== 1'b0 || tx_d !== 2'b00 || busy !== 1'b0 || read_en !== 1'b0) begin
      errors++; $display("FAIL rst_async got tx_en=%b tx_d=%b busy=%b read_en=%b exp 0",
                         tx_en, tx_d, busy, read_en);
    end
    repeat (2) @(negedge clk_50_mhz);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50_mhz);
    fifo_q.delete(); fifo_refresh();
    clear_stats(); exp_q.delete();
    load_frame(30, 30, 0);
    send_wait(16'd30, 2000, to);
    checks++; if (to || n_done != 1 || rx_q.size() != 288) begin
      errors++; $display("FAIL rst_after got to=%0d done=%0d tx=%0d exp 0 1 288", to, n_done, rx_q.size());
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      eb = exp_q.pop_front();
      rb = 8'hxx;
      if (rx_q.size() >= 4) begin
        d0 = rx_q.pop_front(); d1 = rx_q.pop_front();
        d2 = rx_q.pop_front(); d3 = rx_q.pop_front();
        rb = {d3, d2, d1, d0};
      end
      checks++; if (rb !== eb) begin errors++; $display("FAIL rst_byte%0d got %h exp %h", i, rb, eb); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50_mhz);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50_mhz);
    test_crc();
    test_short_pad();
    test_long_counting();
    test_underrun();
    test_ignored_starts();
    test_reset_mid_fcs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
